// File: rtl/frame_loader.sv
// frame_loader: packs a host byte stream into DATA_W-bit sample words and writes
// one frame of DEPTH words into the inference input memory. It then waits for the
// network's classification result and hands it back to the host on a valid/ready
// handshake before re-arming for the next frame.
//
//  state    | meaning
//  ---------+------------------------------------------------------------------
//  LOAD     | accepting bytes, packing three per word, writing words in order
//  WAIT_RES | frame written; waiting for result_valid_i, bounded by TIMEOUT
//  HOLD     | result held on res_valid_o/res_data_o until the host takes it
module frame_loader #(
    parameter int DATA_W  = 19,
    parameter int DEPTH   = 128,
    parameter int ADDR_W  = 7,
    parameter int RES_W   = 7,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    input  logic              result_valid_i,
    input  logic [RES_W-1:0]  result_i,
    output logic              res_valid_o,
    output logic [RES_W-1:0]  res_data_o,
    input  logic              res_ready_i,
    output logic              timeout_err,
    output logic              overrun_err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_LOAD     = 2'd0;
    localparam logic [1:0] ST_WAIT_RES = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    logic [1:0]        state_q,       state_d;
    logic [1:0]        byte_cnt_q,    byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q,    word_cnt_d;
    logic [TMR_W-1:0]  timer_q,       timer_d;
    logic [7:0]        b0_q,          b0_d;
    logic [7:0]        b1_q,          b1_d;
    logic              wr_en_q,       wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,     wr_data_d;
    logic              frame_done_q,  frame_done_d;
    logic              res_valid_q,   res_valid_d;
    logic [RES_W-1:0]  res_data_q,    res_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_err_q, overrun_err_d;

    logic byte_acc;

    // in_ready is held low while rst is asserted so no byte is taken during reset
    assign in_ready = (state_q == ST_LOAD) && !rst;
    assign byte_acc = in_valid && in_ready;

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_done  = frame_done_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign timeout_err = timeout_err_q;
    assign overrun_err = overrun_err_q;

    // Next-state logic: byte packing, word writes, result wait and hand-off
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        timer_d       = timer_q;
        b0_d          = b0_q;
        b1_d          = b1_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        timeout_err_d = timeout_err_q;
        overrun_err_d = overrun_err_q;

        case (state_q)
            ST_LOAD: begin
                if (byte_acc) begin
                    case (byte_cnt_q)
                        2'd0: begin
                            b0_d       = in_data;
                            byte_cnt_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d       = in_data;
                            byte_cnt_d = 2'd2;
                        end
                        default: begin
                            // third byte only contributes its low DATA_W-16 bits
                            byte_cnt_d = 2'd0;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = word_cnt_q;
                            wr_data_d  = {in_data[DATA_W-17:0], b1_q, b0_q};
                            if (word_cnt_q == LAST_ADDR) begin
                                frame_done_d = 1'b1;
                                word_cnt_d   = '0;
                                timer_d      = '0;
                                state_d      = ST_WAIT_RES;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_WAIT_RES: begin
                // a result arriving on the last timer cycle still wins
                if (result_valid_i) begin
                    res_data_d  = result_i;
                    res_valid_d = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_HOLD;
                end else if (timer_q == TMR_LAST) begin
                    timeout_err_d = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_LOAD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (result_valid_i) begin
                    overrun_err_d = 1'b1;
                end
                if (res_valid_q && res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD;
            byte_cnt_q    <= '0;
            word_cnt_q    <= '0;
            timer_q       <= '0;
            b0_q          <= '0;
            b1_q          <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_cnt_q    <= word_cnt_d;
            timer_q       <= timer_d;
            b0_q          <= b0_d;
            b1_q          <= b1_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_done_q  <= frame_done_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            timeout_err_q <= timeout_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed stimulus with a queue-based scoreboard for frame_loader.
module tb_frame_loader;

    localparam int DATA_W  = 19;
    localparam int DEPTH   = 128;
    localparam int ADDR_W  = 7;
    localparam int RES_W   = 7;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              result_valid_i = 1'b0;
    logic [RES_W-1:0]  result_i = '0;
    logic              res_valid_o;
    logic [RES_W-1:0]  res_data_o;
    logic              res_ready_i = 1'b0;
    logic              timeout_err;
    logic              overrun_err;

    frame_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RES_W  (RES_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .result_valid_i(result_valid_i),
        .result_i      (result_i),
        .res_valid_o   (res_valid_o),
        .res_data_o    (res_data_o),
        .res_ready_i   (res_ready_i),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              fd;
    } wr_t;

    wr_t              wr_q[$];
    logic [RES_W-1:0] res_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected memory writes and results whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wr_en: addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                    check("frame_done", 32'(frame_done), 32'(e.fd));
                end
            end else if (frame_done) begin
                n_cmp++;
                n_err++;
                $display("FAIL frame_done_without_wr_en: got 1, expected 0");
            end
            if (res_valid_o && res_ready_i) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got 0x%0h, expected none", res_data_o);
                end else begin
                    logic [RES_W-1:0] r;
                    r = res_q.pop_front();
                    check("res_data_handshake", 32'(res_data_o), 32'(r));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = int'($urandom_range(0, 2));
            repeat (n) tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_wait: got 0 for 100 cycles, expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [DATA_W-1:0] exp_data, input int idx, input bit gaps);
        wr_t e;
        e.addr = ADDR_W'(idx);
        e.data = exp_data;
        e.fd   = (idx == DEPTH - 1);
        wr_q.push_back(e);
        send_byte(b0, gaps);
        send_byte(b1, gaps);
        send_byte(b2, gaps);
    endtask

    task automatic send_frame(input bit gaps, input bit special0);
        logic [7:0] kk;
        for (int k = 0; k < DEPTH; k++) begin
            kk = 8'(k);
            if (special0 && k == 0)
                send_word(8'h34, 8'h12, 8'hFF, 19'h71234, k, gaps);
            else
                send_word(kk, kk, kk & 8'h07, {kk[2:0], kk, kk}, k, gaps);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},       32'(wr_en),       32'd0);
        check({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
        check({tag, "_wr_data"},     32'(wr_data),     32'd0);
        check({tag, "_frame_done"},  32'(frame_done),  32'd0);
        check({tag, "_res_valid"},   32'(res_valid_o), 32'd0);
        check({tag, "_res_data"},    32'(res_data_o),  32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
    endtask

    initial begin
        logic [7:0] kk;

        // reset state
        rst = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        check_all_zero("post_reset");

        // gapless frame, then no result: timeout after exactly TIMEOUT cycles
        send_frame(1'b0, 1'b0);
        check("in_ready_wait_res", 32'(in_ready), 32'd0);
        repeat (TIMEOUT - 1) tick();
        check("timeout_err_early", 32'(timeout_err), 32'd0);
        check("in_ready_before_timeout", 32'(in_ready), 32'd0);
        tick();
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("in_ready_after_timeout", 32'(in_ready), 32'd1);
        check("res_valid_after_timeout", 32'(res_valid_o), 32'd0);

        // frame with gaps and a truncated top byte in word 0, then a held result
        send_frame(1'b1, 1'b1);
        check("overrun_err_clear", 32'(overrun_err), 32'd0);
        result_valid_i = 1'b1;
        result_i       = 7'h05;
        res_q.push_back(7'h05);
        tick();
        result_valid_i = 1'b0;
        result_i       = '0;
        for (int i = 0; i < 10; i++) begin
            check("hold_res_valid", 32'(res_valid_o), 32'd1);
            check("hold_res_data",  32'(res_data_o),  32'h05);
            check("hold_in_ready",  32'(in_ready),    32'd0);
            tick();
        end

        // overrun while holding
        result_valid_i = 1'b1;
        result_i       = 7'h22;
        tick();
        result_valid_i = 1'b0;
        result_i       = '0;
        check("overrun_err_set",      32'(overrun_err), 32'd1);
        check("overrun_res_data",     32'(res_data_o),  32'h05);
        check("overrun_res_valid",    32'(res_valid_o), 32'd1);

        // host takes the result
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("release_res_valid",   32'(res_valid_o), 32'd0);
        check("release_in_ready",    32'(in_ready),    32'd1);
        check("timeout_err_sticky",  32'(timeout_err), 32'd1);
        check("overrun_err_sticky",  32'(overrun_err), 32'd1);

        // partial frame of 200 bytes, reset, then a clean frame with gaps
        for (int k = 0; k < 66; k++) begin
            kk = 8'(k);
            send_word(kk, kk, kk & 8'h07, {kk[2:0], kk, kk}, k, 1'b0);
        end
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("midframe_reset");
        rst = 1'b0;
        tick();
        send_frame(1'b1, 1'b0);
        check("in_ready_after_frame2", 32'(in_ready), 32'd0);

        repeat (3) tick();
        check("wr_queue_drained",  32'(wr_q.size()),  32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
